imm_gen_stage: RTL and testbench
================================

Name: imm_gen_stage

Overview:
Registered, parametrised successor to the combinational immediate generator. Sits between fetch and the register-read stage. Accepts one 32-bit RV instruction per cycle over a valid/ready handshake and emits the XLEN-wide sign-extended immediate, the format code and an illegal-opcode flag one cycle later. Includes a 2-entry skid buffer for full-throughput backpressure, correct shift-amount extraction, RV64 support via XLEN, and a saturating illegal-instruction counter.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
CNT_W, 8, width of the illegal-instruction counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  instruction on in_instr is valid
in_ready  output  1  stage can accept an instruction this cycle
in_instr  input  32  instruction word
out_valid  output  1  out_* fields are valid
out_ready  input  1  consumer accepts the out_* fields this cycle
out_imm  output  XLEN  generated immediate
out_fmt  output  3  format code: R=000, I=001, S=010, B=011, U=100, J=101
out_illegal  output  1  opcode not in the supported set
out_instr  output  32  instruction word, passed through
illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions
cnt_clear  input  1  synchronous clear of illegal_cnt

Behaviour:
- Reset (rst_n=0 at a clock edge): out_valid=0, out_imm=0, out_fmt=000, out_illegal=0, out_instr=0, illegal_cnt=0, skid empty, in_ready=0 while rst_n=0. In the first cycle after release, in_ready=1. Reset mid-transfer discards the main and skid contents.
- Handshake: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready. in_ready is a registered signal equal to "skid empty". Input data must not depend on in_ready combinationally.
- Latency: exactly 1 cycle from input transfer to out_valid when unstalled. Throughput: 1 instruction per cycle with out_ready held high.
- Skid behaviour:
  - If an input transfers while the main register holds unaccepted data, the decoded result goes to the skid register and in_ready drops next cycle.
  - On the next output transfer, skid moves to main and in_ready rises the following cycle.
  - Order is always preserved. No drops, no duplicates.
  - out_* fields are stable while out_valid=1 and out_ready=0.
- Opcode decode (instr[6:0]):
  - 0110111 and 0010111 -> U.
  - 1101111 -> J.
  - 1100111, 0000011, 0010011, 0001111, 1110011 -> I.
  - 1100011 -> B. 0100011 -> S. 0110011 -> R.
  - For XLEN=64 only, 0011011 -> I and 0111011 -> R.
  - Anything else -> fmt=R, imm=0, illegal=1.
- Immediates, all sign-extended from instr[31] to XLEN:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}, sign-extended for XLEN=64.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R = 0.
- Shift immediates: opcode 0010011 with funct3 001 or 101 gives imm = zero-extended shamt. For XLEN=32, shamt = instr[24:20]. For XLEN=64, shamt = instr[25:20]. For XLEN=64 with opcode 0011011, shamt = instr[24:20].
- illegal_cnt:
  - Increments by 1 when an illegal instruction is accepted at the input.
  - Saturates at 2^CNT_W-1.
  - cnt_clear sets it to 0. Clear wins over a simultaneous increment.

Test Plan:
- XLEN=32, out_ready=1, in_instr=0xFFF00093 (addi -1) -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=001, out_illegal=0.
- in_instr=0x12345037 -> out_imm=0x12345000, fmt=100. For XLEN=64, 0x800000B7 -> out_imm=0xFFFFFFFF80000000.
- 0xFE000FE3 (beq -2) -> out_imm=0xFFFFFFFE, fmt=011. 0x41F0D093 (srai 31) -> out_imm=0x0000001F, not 0x41F.
- Back-to-back stream of 4 instructions, out_ready=0 for 3 cycles -> 2 accepted, in_ready=0 from the cycle after the second accept, out_* stable. After out_ready=1 the results emerge in order with no loss.
- CNT_W=2, five accepted 0x0000007F words -> illegal_cnt=3 (saturated), out_illegal=1, out_imm=0. cnt_clear pulsed together with an illegal accept -> illegal_cnt=0.
- Assert rst_n=0 while main and skid are full -> next cycle out_valid=0, illegal_cnt=0, in_ready=0. After release, in_ready=1 and the next input emerges with 1-cycle latency.

Source files
------------

// File: rtl/imm_gen_stage_if.sv
// Handshake and result bundle between fetch, the immediate generator and register read.
// The slave modport is the stage's own view of the bundle; the master modport is the view seen by its neighbours.
interface imm_gen_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_imm;
   logic [2:0]        out_fmt;
   logic              out_illegal;
   logic [31:0]       out_instr;
   logic [CNT_W-1:0]  illegal_cnt;
   logic              cnt_clear;

   modport slave (
      input  in_valid, in_instr, out_ready, cnt_clear,
      output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr, illegal_cnt
   );

   modport master (
      output in_valid, in_instr, out_ready, cnt_clear,
      input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr, illegal_cnt
   );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered immediate generator: decodes one RV instruction per cycle into an XLEN-wide immediate,
// a format code and an illegal flag, with a 2-entry skid buffer and a saturating illegal counter.
//
// state    | meaning
// ST_EMPTY | nothing held, out_valid low
// ST_MAIN  | main register holds a result waiting for the consumer
// ST_FULL  | main and skid both hold results, input held off
module imm_gen_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input logic            clk,
   input logic            rst_n,
   imm_gen_stage_if.slave bus
);
   localparam logic [2:0] FMT_R = 3'b000;
   localparam logic [2:0] FMT_I = 3'b001;
   localparam logic [2:0] FMT_S = 3'b010;
   localparam logic [2:0] FMT_B = 3'b011;
   localparam logic [2:0] FMT_U = 3'b100;
   localparam logic [2:0] FMT_J = 3'b101;
   localparam bit         RV64  = (XLEN == 64);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            illegal;
      logic [31:0]     instr;
   } res_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_MAIN  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   res_t             r_main;
   res_t             r_skid;
   res_t             w_dec;
   logic             r_in_ready;
   logic [CNT_W-1:0] r_cnt;
   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_load_main_in;
   logic             w_load_main_skid;
   logic             w_load_skid;
   logic [6:0]       w_op;
   logic [2:0]       w_f3;
   logic [31:0]      w_imm32;
   logic [31:0]      w_i;

   assign w_i        = bus.in_instr;
   assign w_op       = w_i[6:0];
   assign w_f3       = w_i[14:12];
   assign w_in_fire  = bus.in_valid && r_in_ready;
   assign w_out_fire = (r_state != ST_EMPTY) && bus.out_ready;

   // Immediate is built sign-extended to 32 bits, then widened; shift amounts are small and positive.
   always_comb begin
      w_imm32       = '0;
      w_dec.fmt     = FMT_R;
      w_dec.illegal = 1'b1;
      case (w_op)
         7'b0110111, 7'b0010111: begin
            w_dec.fmt     = FMT_U;
            w_dec.illegal = 1'b0;
            w_imm32       = {w_i[31:12], 12'b0};
         end
         7'b1101111: begin
            w_dec.fmt     = FMT_J;
            w_dec.illegal = 1'b0;
            w_imm32       = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
         end
         7'b1100111, 7'b0000011, 7'b0001111, 7'b1110011: begin
            w_dec.fmt     = FMT_I;
            w_dec.illegal = 1'b0;
            w_imm32       = {{20{w_i[31]}}, w_i[31:20]};
         end
         7'b0010011: begin
            w_dec.fmt     = FMT_I;
            w_dec.illegal = 1'b0;
            if (w_f3 == 3'b001 || w_f3 == 3'b101)
               w_imm32 = RV64 ? {26'b0, w_i[25:20]} : {27'b0, w_i[24:20]};
            else
               w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
         end
         7'b1100011: begin
            w_dec.fmt     = FMT_B;
            w_dec.illegal = 1'b0;
            w_imm32       = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
         end
         7'b0100011: begin
            w_dec.fmt     = FMT_S;
            w_dec.illegal = 1'b0;
            w_imm32       = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
         end
         7'b0110011: begin
            w_dec.illegal = 1'b0;
         end
         7'b0011011: begin
            if (RV64) begin
               w_dec.fmt     = FMT_I;
               w_dec.illegal = 1'b0;
               if (w_f3 == 3'b001 || w_f3 == 3'b101)
                  w_imm32 = {27'b0, w_i[24:20]};
               else
                  w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
            end
         end
         7'b0111011: begin
            if (RV64)
               w_dec.illegal = 1'b0;
         end
         default: begin
         end
      endcase
      w_dec.imm   = XLEN'($signed(w_imm32));
      w_dec.instr = w_i;
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_in_fire) begin
               w_state_nxt    = ST_MAIN;
               w_load_main_in = 1'b1;
            end
         end
         ST_MAIN: begin
            if (w_in_fire && !w_out_fire) begin
               w_state_nxt = ST_FULL;
               w_load_skid = 1'b1;
            end else if (w_in_fire) begin
               w_load_main_in = 1'b1;
            end else if (w_out_fire) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_out_fire) begin
               w_state_nxt      = ST_MAIN;
               w_load_main_skid = 1'b1;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // in_ready mirrors "skid will be empty" but stays low for the whole of reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b0;
         r_main     <= '0;
         r_skid     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_FULL);
         if (w_load_main_in)
            r_main <= w_dec;
         else if (w_load_main_skid)
            r_main <= r_skid;
         if (w_load_skid)
            r_skid <= w_dec;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (bus.cnt_clear)
         r_cnt <= '0;
      else if (w_in_fire && w_dec.illegal && (r_cnt != '1))
         r_cnt <= r_cnt + CNT_W'(1);
   end

   assign bus.in_ready    = r_in_ready;
   assign bus.out_valid   = (r_state != ST_EMPTY);
   assign bus.out_imm     = r_main.imm;
   assign bus.out_fmt     = r_main.fmt;
   assign bus.out_illegal = r_main.illegal;
   assign bus.out_instr   = r_main.instr;
   assign bus.illegal_cnt = r_cnt;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: an RV32 (2-bit counter) and an RV64 instance share one stimulus stream,
// with a per-instance scoreboard of hand-computed expected results.
module tb_imm_gen_stage;
   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm32;
      logic [63:0] imm64;
      logic [2:0]  fmt32;
      logic [2:0]  fmt64;
      logic        ill32;
      logic        ill64;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tb_in_valid = 1'b0;
   logic        tb_out_ready = 1'b0;
   logic        tb_cnt_clear = 1'b0;
   logic [31:0] tb_in_instr = '0;

   int   n_tests = 0;
   int   n_fail = 0;
   vec_t cur_vec;
   vec_t mon_e32;
   vec_t mon_e64;
   vec_t q32[$];
   vec_t q64[$];
   vec_t tbl[19];

   imm_gen_stage_if #(.XLEN(32), .CNT_W(2)) bus32 ();
   imm_gen_stage_if #(.XLEN(64), .CNT_W(8)) bus64 ();

   assign bus32.in_valid  = tb_in_valid;
   assign bus32.in_instr  = tb_in_instr;
   assign bus32.out_ready = tb_out_ready;
   assign bus32.cnt_clear = tb_cnt_clear;
   assign bus64.in_valid  = tb_in_valid;
   assign bus64.in_instr  = tb_in_instr;
   assign bus64.out_ready = tb_out_ready;
   assign bus64.cnt_clear = tb_cnt_clear;

   imm_gen_stage #(.XLEN(32), .CNT_W(2)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
   imm_gen_stage #(.XLEN(64), .CNT_W(8)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64.slave));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: pop on output transfer, push on input transfer, both sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus32.out_valid && bus32.out_ready) begin
            check("dut32_has_expected", 64'(q32.size() != 0), 64'd1);
            if (q32.size() != 0) begin
               mon_e32 = q32.pop_front();
               check("dut32_imm",   64'(bus32.out_imm),     64'(mon_e32.imm32));
               check("dut32_fmt",   64'(bus32.out_fmt),     64'(mon_e32.fmt32));
               check("dut32_ill",   64'(bus32.out_illegal), 64'(mon_e32.ill32));
               check("dut32_instr", 64'(bus32.out_instr),   64'(mon_e32.instr));
            end
         end
         if (bus64.out_valid && bus64.out_ready) begin
            check("dut64_has_expected", 64'(q64.size() != 0), 64'd1);
            if (q64.size() != 0) begin
               mon_e64 = q64.pop_front();
               check("dut64_imm",   bus64.out_imm,          mon_e64.imm64);
               check("dut64_fmt",   64'(bus64.out_fmt),     64'(mon_e64.fmt64));
               check("dut64_ill",   64'(bus64.out_illegal), 64'(mon_e64.ill64));
               check("dut64_instr", 64'(bus64.out_instr),   64'(mon_e64.instr));
            end
         end
         if (bus32.in_valid && bus32.in_ready) q32.push_back(cur_vec);
         if (bus64.in_valid && bus64.in_ready) q64.push_back(cur_vec);
      end
   end

   task automatic drive(input vec_t v);
      cur_vec     = v;
      tb_in_instr = v.instr;
      tb_in_valid = 1'b1;
   endtask

   task automatic send(input vec_t v);
      logic acc;
      int   budget;
      drive(v);
      budget = 0;
      do begin
         acc = bus32.in_ready;
         @(posedge clk);
         #1;
         budget++;
      end while (!acc && budget < 50);
      check("send_accepted", 64'(acc), 64'd1);
   endtask

   task automatic idle(input int n);
      tb_in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1, 1'b0, 1'b0};
      tbl[1]  = '{32'h12345037, 32'h12345000, 64'h0000000012345000, 3'd4, 3'd4, 1'b0, 1'b0};
      tbl[2]  = '{32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 3'd4, 1'b0, 1'b0};
      tbl[3]  = '{32'hFE000FE3, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 3'd3, 3'd3, 1'b0, 1'b0};
      tbl[4]  = '{32'h41F0D093, 32'h0000001F, 64'h000000000000001F, 3'd1, 3'd1, 1'b0, 1'b0};
      tbl[5]  = '{32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b1};
      tbl[6]  = '{32'h03F0909B, 32'h00000000, 64'h000000000000001F, 3'd0, 3'd1, 1'b1, 1'b0};
      tbl[7]  = '{32'h03F09093, 32'h0000001F, 64'h000000000000003F, 3'd1, 3'd1, 1'b0, 1'b0};
      tbl[8]  = '{32'h80000FA3, 32'hFFFFF81F, 64'hFFFFFFFFFFFFF81F, 3'd2, 3'd2, 1'b0, 1'b0};
      tbl[9]  = '{32'h800000EF, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 3'd5, 3'd5, 1'b0, 1'b0};
      tbl[10] = '{32'h0010006F, 32'h00000800, 64'h0000000000000800, 3'd5, 3'd5, 1'b0, 1'b0};
      tbl[11] = '{32'h003100B3, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b0, 1'b0};
      tbl[12] = '{32'h0000003B, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b0};
      tbl[13] = '{32'hFFFFF097, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 3'd4, 3'd4, 1'b0, 1'b0};
      tbl[14] = '{32'h80002083, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 3'd1, 3'd1, 1'b0, 1'b0};
      tbl[15] = '{32'h00408067, 32'h00000004, 64'h0000000000000004, 3'd1, 3'd1, 1'b0, 1'b0};
      tbl[16] = '{32'h30200073, 32'h00000302, 64'h0000000000000302, 3'd1, 3'd1, 1'b0, 1'b0};
      tbl[17] = '{32'h0FF0000F, 32'h000000FF, 64'h00000000000000FF, 3'd1, 3'd1, 1'b0, 1'b0};
      tbl[18] = '{32'hFFF0D083, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1, 1'b0, 1'b0};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid32", 64'(bus32.out_valid), 64'd0);
      check("rst_in_ready32",  64'(bus32.in_ready),  64'd0);
      check("rst_out_imm32",   64'(bus32.out_imm),   64'd0);
      check("rst_out_fmt32",   64'(bus32.out_fmt),   64'd0);
      check("rst_out_ill32",   64'(bus32.out_illegal), 64'd0);
      check("rst_out_instr32", 64'(bus32.out_instr), 64'd0);
      check("rst_cnt32",       64'(bus32.illegal_cnt), 64'd0);
      check("rst_out_valid64", 64'(bus64.out_valid), 64'd0);
      check("rst_in_ready64",  64'(bus64.in_ready),  64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("release_in_ready32", 64'(bus32.in_ready), 64'd1);
      check("release_in_ready64", 64'(bus64.in_ready), 64'd1);

      // single instruction latency
      tb_out_ready = 1'b1;
      send(tbl[0]);
      check("lat_out_valid32", 64'(bus32.out_valid), 64'd1);
      check("lat_out_imm32",   64'(bus32.out_imm),   64'hFFFFFFFF);
      check("lat_out_fmt32",   64'(bus32.out_fmt),   64'd1);
      check("lat_out_imm64",   bus64.out_imm,        64'hFFFFFFFFFFFFFFFF);
      idle(2);

      // full-rate stream of the vector table
      foreach (tbl[i]) send(tbl[i]);
      idle(3);
      check("cnt32_after_table", 64'(bus32.illegal_cnt), 64'd3);
      check("cnt64_after_table", 64'(bus64.illegal_cnt), 64'd1);

      // backpressure: out_ready low for three edges while four words are offered
      tb_out_ready = 1'b0;
      drive(tbl[0]);
      @(posedge clk);
      #1;
      check("stall_ready_after_a", 64'(bus32.in_ready),  64'd1);
      check("stall_instr_a",       64'(bus32.out_instr), 64'(tbl[0].instr));
      drive(tbl[1]);
      @(posedge clk);
      #1;
      check("stall_ready_after_b", 64'(bus32.in_ready),  64'd0);
      check("stall_instr_b",       64'(bus32.out_instr), 64'(tbl[0].instr));
      drive(tbl[3]);
      @(posedge clk);
      #1;
      check("stall_ready_c",   64'(bus32.in_ready),  64'd0);
      check("stall_valid_c",   64'(bus32.out_valid), 64'd1);
      check("stall_instr_c",   64'(bus32.out_instr), 64'(tbl[0].instr));
      check("stall_imm_c",     64'(bus32.out_imm),   64'hFFFFFFFF);
      check("stall_instr64_c", 64'(bus64.out_instr), 64'(tbl[0].instr));
      tb_out_ready = 1'b1;
      send(tbl[3]);
      send(tbl[4]);
      idle(3);

      // counter saturation and clear priority
      tb_cnt_clear = 1'b1;
      @(posedge clk);
      #1;
      tb_cnt_clear = 1'b0;
      check("cnt32_cleared", 64'(bus32.illegal_cnt), 64'd0);
      for (int k = 1; k <= 5; k++) begin
         send(tbl[5]);
         check("cnt32_sat", 64'(bus32.illegal_cnt), (k < 3) ? 64'(k) : 64'd3);
         check("cnt64_inc", 64'(bus64.illegal_cnt), 64'(k));
      end
      idle(2);
      drive(tbl[5]);
      tb_cnt_clear = 1'b1;
      check("clr_accept_ready", 64'(bus32.in_ready), 64'd1);
      @(posedge clk);
      #1;
      tb_cnt_clear = 1'b0;
      tb_in_valid  = 1'b0;
      check("clr_wins32", 64'(bus32.illegal_cnt), 64'd0);
      check("clr_wins64", 64'(bus64.illegal_cnt), 64'd0);
      idle(2);

      // reset with main and skid both occupied
      tb_out_ready = 1'b0;
      drive(tbl[5]);
      @(posedge clk);
      #1;
      drive(tbl[0]);
      @(posedge clk);
      #1;
      tb_in_valid = 1'b0;
      check("full_in_ready",  64'(bus32.in_ready),    64'd0);
      check("full_cnt32",     64'(bus32.illegal_cnt), 64'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      q32.delete();
      q64.delete();
      check("midrst_out_valid32", 64'(bus32.out_valid),   64'd0);
      check("midrst_cnt32",       64'(bus32.illegal_cnt), 64'd0);
      check("midrst_in_ready32",  64'(bus32.in_ready),    64'd0);
      check("midrst_out_valid64", 64'(bus64.out_valid),   64'd0);
      rst_n        = 1'b1;
      tb_out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_release_ready", 64'(bus32.in_ready), 64'd1);
      send(tbl[1]);
      check("midrst_lat_valid", 64'(bus32.out_valid), 64'd1);
      check("midrst_lat_instr", 64'(bus32.out_instr), 64'(tbl[1].instr));
      idle(3);

      check("q32_drained", 64'(q32.size()), 64'd0);
      check("q64_drained", 64'(q64.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
